// File: rtl/axi_sdram_rw_arbiter_if.sv
// Bus bundle between the AXI read/write address channels, the arbiter and
// the SDRAM controller command port. The arbiter uses the slave modport; the
// master modport is the view seen by whatever drives the AXI side and
// consumes the commands.
interface axi_sdram_rw_arbiter_if #(
  parameter int addr_width = 32
);
  logic [addr_width-1:0] araddr;
  logic [7:0]            arlen;
  logic                  arvalid;
  logic                  arready;
  logic [addr_width-1:0] awaddr;
  logic [7:0]            awlen;
  logic                  awvalid;
  logic                  awready;
  logic [addr_width-1:0] cmd_addr;
  logic [7:0]            cmd_len;
  logic                  cmd_rw;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  burst_done;

  modport slave (
    input  araddr, arlen, arvalid,
    output arready,
    input  awaddr, awlen, awvalid,
    output awready,
    output cmd_addr, cmd_len, cmd_rw, cmd_valid,
    input  cmd_ready, burst_done
  );

  modport master (
    output araddr, arlen, arvalid,
    input  arready,
    output awaddr, awlen, awvalid,
    input  awready,
    input  cmd_addr, cmd_len, cmd_rw, cmd_valid,
    output cmd_ready, burst_done
  );
endinterface

// File: rtl/axi_sdram_rw_arbiter.sv
// Read/write burst arbiter in front of an SDRAM controller. Accepts one AXI
// read or write address at a time, forwards it as a single command and waits
// for burst_done before arbitrating again, so exactly one burst is ever
// outstanding.
//
// Build option: define ARB_WR_PRIO_EN for write-priority arbitration, where
// writes win ties until wr_burst_limit consecutive writes have been granted
// while a read was waiting. Without it, ties are resolved round-robin.
module axi_sdram_rw_arbiter #(
  parameter int addr_width     = 32,
  parameter int wr_burst_limit = 4
) (
  input logic                   clk,
  input logic                   rst,
  axi_sdram_rw_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t                state;
  logic [addr_width-1:0] cmd_addr_r;
  logic [7:0]            cmd_len_r;
  logic                  cmd_rw_r;
  logic                  cmd_valid_r;
  logic                  grant_rd;
  logic                  grant_wr;
  logic                  rd_hs;
  logic                  wr_hs;

  if (wr_burst_limit < 1) begin : g_limit_check
    $error("wr_burst_limit must be at least 1");
  end

`ifdef ARB_WR_PRIO_EN
  localparam int STREAK_W = $clog2(wr_burst_limit + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(wr_burst_limit);

  logic [STREAK_W-1:0] wr_streak;

  // Write wins a tie unless it has already starved the read channel for
  // wr_burst_limit consecutive grants.
  always_comb begin
    grant_rd = bus.arvalid && (!bus.awvalid || (wr_streak == STREAK_MAX));
    grant_wr = bus.awvalid && !grant_rd;
  end
`else
  logic last_grant_rd;

  // Round-robin: on a tie, grant whichever channel was not granted last.
  always_comb begin
    grant_rd = bus.arvalid && (!bus.awvalid || !last_grant_rd);
    grant_wr = bus.awvalid && !grant_rd;
  end
`endif

  // Ready is only offered in IDLE, so a ready is itself the handshake.
  always_comb begin
    rd_hs = (state == IDLE) && !rst && grant_rd;
    wr_hs = (state == IDLE) && !rst && grant_wr;
  end

  assign bus.arready   = rd_hs;
  assign bus.awready   = wr_hs;
  assign bus.cmd_addr  = cmd_addr_r;
  assign bus.cmd_len   = cmd_len_r;
  assign bus.cmd_rw    = cmd_rw_r;
  assign bus.cmd_valid = cmd_valid_r;

  // Burst-tracking FSM: latch the granted address, present it until the
  // controller takes it, then wait for the burst to finish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cmd_valid_r <= 1'b0;
      cmd_addr_r  <= '0;
      cmd_len_r   <= '0;
      cmd_rw_r    <= 1'b0;
`ifdef ARB_WR_PRIO_EN
      wr_streak   <= '0;
`else
      last_grant_rd <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (rd_hs) begin
            cmd_addr_r  <= bus.araddr;
            cmd_len_r   <= bus.arlen;
            cmd_rw_r    <= 1'b1;
            cmd_valid_r <= 1'b1;
            state       <= ISSUE;
`ifdef ARB_WR_PRIO_EN
            wr_streak   <= '0;
`else
            last_grant_rd <= 1'b1;
`endif
          end else if (wr_hs) begin
            cmd_addr_r  <= bus.awaddr;
            cmd_len_r   <= bus.awlen;
            cmd_rw_r    <= 1'b0;
            cmd_valid_r <= 1'b1;
            state       <= ISSUE;
`ifdef ARB_WR_PRIO_EN
            // Count only writes that made a read wait.
            if (bus.arvalid && (wr_streak != STREAK_MAX)) begin
              wr_streak <= wr_streak + 1'b1;
            end
`else
            last_grant_rd <= 1'b0;
`endif
          end
        end
        ISSUE: begin
          if (bus.cmd_ready) begin
            cmd_valid_r <= 1'b0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (bus.burst_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sdram_rw_arbiter.sv
// Testbench for axi_sdram_rw_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model. Follows ARB_WR_PRIO_EN
// when the bundle is built with it.
module tb_axi_sdram_rw_arbiter;
  localparam int AW       = 32;
  localparam int WR_LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  axi_sdram_rw_arbiter_if #(.addr_width(AW)) bus ();

  axi_sdram_rw_arbiter #(
    .addr_width(AW),
    .wr_burst_limit(WR_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    bus.araddr     = '0;
    bus.arlen      = '0;
    bus.arvalid    = 1'b0;
    bus.awaddr     = '0;
    bus.awlen      = '0;
    bus.awvalid    = 1'b0;
    bus.cmd_ready  = 1'b0;
    bus.burst_done = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b0;
    #3;
    rst = 1'b1;
    bus.arvalid = 1'b1;
    bus.awvalid = 1'b1;
    tick();
    #1;
    checks++; if (bus.arready !== 1'b0) begin failures++; $display("FAIL reset_arready: got %b expected 0", bus.arready); end
    checks++; if (bus.awready !== 1'b0) begin failures++; $display("FAIL reset_awready: got %b expected 0", bus.awready); end
    checks++; if (bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_cmd_valid: got %b expected 0", bus.cmd_valid); end
    checks++; if (bus.cmd_addr !== '0) begin failures++; $display("FAIL reset_cmd_addr: got %h expected 0", bus.cmd_addr); end
    checks++; if (bus.cmd_len !== 8'd0) begin failures++; $display("FAIL reset_cmd_len: got %h expected 0", bus.cmd_len); end
    checks++; if (bus.cmd_rw !== 1'b0) begin failures++; $display("FAIL reset_cmd_rw: got %b expected 0", bus.cmd_rw); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_idle();
  endtask

  task automatic test_single_read();
    do_reset();
    bus.araddr  = 32'h100;
    bus.arlen   = 8'd7;
    bus.arvalid = 1'b1;
    #1;
    checks++; if (bus.arready !== 1'b1) begin failures++; $display("FAIL single_arready: got %b expected 1", bus.arready); end
    checks++; if (bus.awready !== 1'b0) begin failures++; $display("FAIL single_awready: got %b expected 0", bus.awready); end
    tick();
    bus.arvalid = 1'b0;
    #1;
    checks++; if (bus.cmd_valid !== 1'b1) begin failures++; $display("FAIL single_cmd_valid: got %b expected 1", bus.cmd_valid); end
    checks++; if (bus.cmd_rw !== 1'b1) begin failures++; $display("FAIL single_cmd_rw: got %b expected 1", bus.cmd_rw); end
    checks++; if (bus.cmd_addr !== 32'h100) begin failures++; $display("FAIL single_cmd_addr: got %h expected 100", bus.cmd_addr); end
    checks++; if (bus.cmd_len !== 8'd7) begin failures++; $display("FAIL single_cmd_len: got %h expected 7", bus.cmd_len); end
    drive_idle();
  endtask

  task automatic test_grant_sequence();
    bit exp_rd [10];
    int n;
    int last_cyc;
    bit prev_cv;
    bit last_rd;
    for (int i = 0; i < 10; i++) begin
`ifdef ARB_WR_PRIO_EN
      exp_rd[i] = ((i % 5) == 4);
`else
      exp_rd[i] = ((i % 2) == 0);
`endif
    end
    n        = 0;
    last_cyc = -1;
    prev_cv  = 1'b0;
    last_rd  = 1'b0;
    do_reset();
    bus.arvalid   = 1'b1;
    bus.awvalid   = 1'b1;
    bus.araddr    = 32'hA000;
    bus.awaddr    = 32'hB000;
    bus.arlen     = 8'd1;
    bus.awlen     = 8'd2;
    bus.cmd_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
      bus.burst_done = prev_cv;
      #1;
      if (bus.arready || bus.awready) begin
        checks++; if (bus.arready && bus.awready) begin failures++; $display("FAIL seq_both_ready: got 1 expected 0 at grant %0d", n); end
        checks++; if (bus.arready !== exp_rd[n]) begin failures++; $display("FAIL seq_grant_%0d: got rd=%b expected rd=%b", n, bus.arready, exp_rd[n]); end
        if (n > 0) begin
          checks++; if (cyc - last_cyc != 3) begin failures++; $display("FAIL seq_spacing_%0d: got %0d expected 3", n, cyc - last_cyc); end
        end
        last_rd  = bus.arready;
        last_cyc = cyc;
        n++;
      end
      if (bus.cmd_valid) begin
        checks++; if (bus.cmd_rw !== last_rd) begin failures++; $display("FAIL seq_cmd_rw: got %b expected %b", bus.cmd_rw, last_rd); end
        checks++; if (bus.cmd_addr !== (last_rd ? 32'hA000 : 32'hB000)) begin failures++; $display("FAIL seq_cmd_addr: got %h expected %h", bus.cmd_addr, last_rd ? 32'hA000 : 32'hB000); end
      end
      prev_cv = bus.cmd_valid;
      tick();
    end
    checks++; if (n != 10) begin failures++; $display("FAIL seq_grant_count: got %0d expected 10", n); end
    drive_idle();
  endtask

  task automatic test_stall();
    do_reset();
    bus.awaddr  = 32'h2345;
    bus.awlen   = 8'd3;
    bus.awvalid = 1'b1;
    #1;
    checks++; if (bus.awready !== 1'b1) begin failures++; $display("FAIL stall_awready: got %b expected 1", bus.awready); end
    tick();
    bus.awaddr  = 32'hDEAD;
    bus.awlen   = 8'd99;
    bus.arvalid = 1'b1;
    bus.araddr  = 32'hBEEF;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.cmd_valid !== 1'b1) begin failures++; $display("FAIL stall_cmd_valid_%0d: got %b expected 1", i, bus.cmd_valid); end
      checks++; if (bus.cmd_rw !== 1'b0) begin failures++; $display("FAIL stall_cmd_rw_%0d: got %b expected 0", i, bus.cmd_rw); end
      checks++; if (bus.cmd_addr !== 32'h2345) begin failures++; $display("FAIL stall_cmd_addr_%0d: got %h expected 2345", i, bus.cmd_addr); end
      checks++; if (bus.cmd_len !== 8'd3) begin failures++; $display("FAIL stall_cmd_len_%0d: got %h expected 3", i, bus.cmd_len); end
      checks++; if (bus.arready !== 1'b0 || bus.awready !== 1'b0) begin failures++; $display("FAIL stall_ready_%0d: got %b%b expected 00", i, bus.arready, bus.awready); end
      tick();
    end
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    #1;
    checks++; if (bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL stall_accept_cmd_valid: got %b expected 0", bus.cmd_valid); end
    checks++; if (bus.arready !== 1'b0) begin failures++; $display("FAIL stall_busy_arready: got %b expected 0", bus.arready); end
    drive_idle();
  endtask

  task automatic test_burst_done_ignored();
    do_reset();
    bus.burst_done = 1'b1;
    #1;
    checks++; if (bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL bd_idle_cmd_valid: got %b expected 0", bus.cmd_valid); end
    tick();
    bus.burst_done = 1'b0;
    bus.arvalid    = 1'b1;
    bus.araddr     = 32'h44;
    #1;
    checks++; if (bus.arready !== 1'b1) begin failures++; $display("FAIL bd_idle_arready: got %b expected 1", bus.arready); end
    tick();
    bus.arvalid    = 1'b0;
    bus.burst_done = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (bus.cmd_valid !== 1'b1) begin failures++; $display("FAIL bd_issue_cmd_valid_%0d: got %b expected 1", i, bus.cmd_valid); end
      tick();
    end
    bus.burst_done = 1'b0;
    bus.cmd_ready  = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    bus.arvalid   = 1'b1;
    bus.araddr    = 32'h55;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (bus.arready !== 1'b0) begin failures++; $display("FAIL bd_busy_arready_%0d: got %b expected 0", i, bus.arready); end
      checks++; if (bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL bd_busy_cmd_valid_%0d: got %b expected 0", i, bus.cmd_valid); end
      tick();
    end
    bus.burst_done = 1'b1;
    #1;
    checks++; if (bus.arready !== 1'b0) begin failures++; $display("FAIL bd_done_arready: got %b expected 0", bus.arready); end
    tick();
    bus.burst_done = 1'b0;
    #1;
    checks++; if (bus.arready !== 1'b1) begin failures++; $display("FAIL bd_back_idle_arready: got %b expected 1", bus.arready); end
    drive_idle();
  endtask

  task automatic test_reset_mid_burst();
    bit exp_rd;
`ifdef ARB_WR_PRIO_EN
    exp_rd = 1'b0;
`else
    exp_rd = 1'b1;
`endif
    do_reset();
    bus.arvalid = 1'b1;
    bus.araddr  = 32'h300;
    bus.arlen   = 8'd5;
    #1;
    checks++; if (bus.arready !== 1'b1) begin failures++; $display("FAIL rmb_first_arready: got %b expected 1", bus.arready); end
    tick();
    bus.arvalid   = 1'b0;
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    bus.arvalid   = 1'b1;
    bus.awvalid   = 1'b1;
    bus.awaddr    = 32'h400;
    #1;
    checks++; if (bus.awready !== 1'b0) begin failures++; $display("FAIL rmb_busy_awready: got %b expected 0", bus.awready); end
    rst = 1'b1;
    #1;
    checks++; if (bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL rmb_cmd_valid: got %b expected 0", bus.cmd_valid); end
    checks++; if (bus.cmd_addr !== '0) begin failures++; $display("FAIL rmb_cmd_addr: got %h expected 0", bus.cmd_addr); end
    checks++; if (bus.cmd_len !== 8'd0) begin failures++; $display("FAIL rmb_cmd_len: got %h expected 0", bus.cmd_len); end
    checks++; if (bus.cmd_rw !== 1'b0) begin failures++; $display("FAIL rmb_cmd_rw: got %b expected 0", bus.cmd_rw); end
    checks++; if (bus.arready !== 1'b0 || bus.awready !== 1'b0) begin failures++; $display("FAIL rmb_ready_in_rst: got %b%b expected 00", bus.arready, bus.awready); end
    tick();
    #1;
    checks++; if (bus.arready !== 1'b0 || bus.awready !== 1'b0) begin failures++; $display("FAIL rmb_ready_held_rst: got %b%b expected 00", bus.arready, bus.awready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++; if (bus.arready !== exp_rd) begin failures++; $display("FAIL rmb_tie_arready: got %b expected %b", bus.arready, exp_rd); end
    checks++; if (bus.awready !== !exp_rd) begin failures++; $display("FAIL rmb_tie_awready: got %b expected %b", bus.awready, !exp_rd); end
    drive_idle();
  endtask

  // Transaction-level model: a command is either waiting for the
  // controller, or its burst is running, or the arbiter is free.
  task automatic test_random();
    bit                m_pend;
    bit                m_open;
    logic [AW-1:0]     m_addr;
    logic [7:0]        m_len;
    bit                m_rw;
    bit                e_ar;
    bit                e_aw;
    bit                av;
    bit                wv;
    logic [AW-1:0]     ra;
    logic [AW-1:0]     wa;
    logic [7:0]        rl;
    logic [7:0]        wl;
`ifdef ARB_WR_PRIO_EN
    int                m_streak;
    m_streak = 0;
`else
    bit                m_last_rd;
    m_last_rd = 1'b0;
`endif
    m_pend = 1'b0;
    m_open = 1'b0;
    m_addr = '0;
    m_len  = '0;
    m_rw   = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      av = ($urandom_range(0, 99) < 60);
      wv = ($urandom_range(0, 99) < 60);
      ra = $urandom;
      wa = $urandom;
      rl = 8'($urandom_range(0, 255));
      wl = 8'($urandom_range(0, 255));
      bus.arvalid    = av;
      bus.awvalid    = wv;
      bus.araddr     = ra;
      bus.awaddr     = wa;
      bus.arlen      = rl;
      bus.awlen      = wl;
      bus.cmd_ready  = ($urandom_range(0, 99) < 50);
      bus.burst_done = ($urandom_range(0, 99) < 40);
      #1;
      e_ar = 1'b0;
      e_aw = 1'b0;
      if (!m_pend && !m_open) begin
        if (av && wv) begin
`ifdef ARB_WR_PRIO_EN
          if (m_streak >= WR_LIMIT) e_ar = 1'b1; else e_aw = 1'b1;
`else
          if (m_last_rd) e_aw = 1'b1; else e_ar = 1'b1;
`endif
        end else begin
          e_ar = av;
          e_aw = wv;
        end
      end
      checks++; if (bus.arready !== e_ar) begin failures++; $display("FAIL rnd_arready cyc %0d: got %b expected %b", cyc, bus.arready, e_ar); end
      checks++; if (bus.awready !== e_aw) begin failures++; $display("FAIL rnd_awready cyc %0d: got %b expected %b", cyc, bus.awready, e_aw); end
      checks++; if (bus.cmd_valid !== m_pend) begin failures++; $display("FAIL rnd_cmd_valid cyc %0d: got %b expected %b", cyc, bus.cmd_valid, m_pend); end
      if (m_pend) begin
        checks++; if (bus.cmd_addr !== m_addr || bus.cmd_len !== m_len || bus.cmd_rw !== m_rw) begin
          failures++;
          $display("FAIL rnd_cmd cyc %0d: got %h/%h/%b expected %h/%h/%b", cyc, bus.cmd_addr, bus.cmd_len, bus.cmd_rw, m_addr, m_len, m_rw);
        end
      end
      if (e_ar) begin
        m_pend = 1'b1; m_addr = ra; m_len = rl; m_rw = 1'b1;
`ifdef ARB_WR_PRIO_EN
        m_streak = 0;
`else
        m_last_rd = 1'b1;
`endif
      end else if (e_aw) begin
        m_pend = 1'b1; m_addr = wa; m_len = wl; m_rw = 1'b0;
`ifdef ARB_WR_PRIO_EN
        if (av && m_streak < WR_LIMIT) m_streak++;
`else
        m_last_rd = 1'b0;
`endif
      end else if (m_pend && bus.cmd_ready) begin
        m_pend = 1'b0;
        m_open = 1'b1;
      end else if (m_open && bus.burst_done) begin
        m_open = 1'b0;
      end
      tick();
    end
    drive_idle();
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();
    test_reset();
    test_single_read();
    test_grant_sequence();
    test_stall();
    test_burst_done_ignored();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_sdram_rw_arbiter.md
AXI_SDRAM_RW_ARBITER -- requirements
Module: axi_sdram_rw_arbiter

Interface
REQ-001 Parameter addr_width, default 32: width of AXI addresses and of cmd_addr.
REQ-002 Parameter wr_burst_limit, default 4: maximum consecutive write grants while a read is pending; used only with ARB_WR_PRIO_EN.
REQ-003 Single clock domain; reset asynchronous, active-high.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 araddr  in  addr_width  AXI read burst address.
REQ-007 arlen  in  8  AXI read burst length minus 1.
REQ-008 arvalid  in  1  read address valid.
REQ-009 arready  out  1  read address accepted.
REQ-010 awaddr  in  addr_width  AXI write burst address.
REQ-011 awlen  in  8  AXI write burst length minus 1.
REQ-012 awvalid  in  1  write address valid.
REQ-013 awready  out  1  write address accepted.
REQ-014 cmd_addr  out  addr_width  burst address to SDRAM controller.
REQ-015 cmd_len  out  8  burst length minus 1.
REQ-016 cmd_rw  out  1  1 = read, 0 = write.
REQ-017 cmd_valid  out  1  command valid.
REQ-018 cmd_ready  in  1  controller accepts command.
REQ-019 burst_done  in  1  single-cycle pulse: current burst finished.

Function
REQ-020 FSM states IDLE, ISSUE, BUSY; exactly one burst outstanding at any time.
REQ-021 IDLE: arready/awready driven combinationally, at most one high, only for the granted channel with valid asserted; both low when no valid.
REQ-022 Channel handshake (valid & ready) in IDLE latches addr, len, rw into cmd registers; next state ISSUE.
REQ-023 ISSUE: cmd_valid = 1, cmd_* held stable; cmd_ready -> BUSY next cycle; arready = awready = 0.
REQ-024 BUSY: cmd_valid = 0, ready outputs 0; burst_done -> IDLE next cycle.
REQ-025 burst_done outside BUSY ignored, no state change.
REQ-026 Minimum grant-to-grant spacing: 3 cycles (IDLE, ISSUE, BUSY with immediate cmd_ready and burst_done).
REQ-027 Default arbitration round-robin: 1-bit last_grant register; both valid in IDLE -> grant channel not granted last; only one valid -> grant it.
REQ-028 Tie at first arbitration after reset grants read (last_grant reset = write).
REQ-029 last_grant updates only on a channel handshake.
REQ-030 Deassertion of arvalid/awvalid before handshake is tolerated; arbitration re-evaluated every IDLE cycle.
REQ-031 cmd_len passes arlen/awlen unmodified; no address alignment or boundary splitting.

Reset
REQ-032 On rst: state IDLE, cmd_valid 0, cmd_addr 0, cmd_len 0, cmd_rw 0, last_grant write, wr_streak 0; arready/awready 0 while rst high.
REQ-033 Reset mid-burst (ISSUE or BUSY) abandons the command; no pending state retained; after release, first handshake follows REQ-028.

Configuration
REQ-034 Macro ARB_WR_PRIO_EN selects write-priority arbitration.
REQ-035 With ARB_WR_PRIO_EN: both valid -> grant write unless wr_streak = wr_burst_limit, then grant read; wr_streak increments on a write handshake while arvalid high, clears on any read handshake, saturates at wr_burst_limit.
REQ-036 Without ARB_WR_PRIO_EN: wr_streak logic absent; round-robin per REQ-027; wr_burst_limit unused.

Verification
REQ-037 Reset, arvalid=1 araddr=0x100 arlen=7 -> arready high in cycle 1; next cycle cmd_valid=1 cmd_rw=1 cmd_addr=0x100 cmd_len=7.
REQ-038 arvalid and awvalid held high, cmd_ready=1, burst_done 1 cycle after cmd accept, default build -> grants alternate R,W,R,W.
REQ-039 cmd_ready held 0 for 5 cycles in ISSUE -> cmd_valid and cmd_* stable, arready=awready=0 throughout.
REQ-040 burst_done pulsed in IDLE and ISSUE -> no state change; first burst_done in BUSY returns to IDLE.
REQ-041 ARB_WR_PRIO_EN, wr_burst_limit=4, both valid continuously -> sequence W,W,W,W,R,W,W,W,W,R.
REQ-042 rst asserted in BUSY with awvalid=1 -> outputs per REQ-032 immediately; after release, tie grants read.
